// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: one WIDTH-bit operation executed LSB first on a
// single 1-bit slice, with the slice carry held in a flop between bits.
// cntrl: 000 B, 010 A+B, 011 A-B, 100 A&B, 101 A|B, 110 A^B; 001/111 give 0.
module alu_serial_seq #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [2:0]       i_cntrl,
    output logic             o_ready,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result,
    output logic             o_zero,
    output logic             o_negative,
    output logic             o_overflow,
    output logic             o_carry_out
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LastIdx = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e             r_state;
    state_e             w_state_next;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [2:0]         r_op;
    logic               r_carry;
    logic [WIDTH-1:0]   r_result;
    logic               r_zero;
    logic               r_negative;
    logic               r_overflow;
    logic               r_carry_out;

    logic               w_accept;
    logic               w_last;
    logic               w_arith;
    logic               w_b_eff;
    logic               w_sum;
    logic               w_cout;
    logic               w_bit;
    logic [WIDTH-1:0]   w_result_next;

    // 1-bit ALU slice; B is inverted into the adder for subtract
    always_comb begin
        w_arith       = (r_op[2:1] == 2'b01);
        w_b_eff       = r_b_sh[0] ^ r_op[0];
        w_sum         = r_a_sh[0] ^ w_b_eff ^ r_carry;
        w_cout        = (r_a_sh[0] & w_b_eff) | (r_carry & (r_a_sh[0] ^ w_b_eff));
        w_bit         = 1'b0;
        case (r_op)
            3'b000:  w_bit = r_b_sh[0];
            3'b010,
            3'b011:  w_bit = w_sum;
            3'b100:  w_bit = r_a_sh[0] & r_b_sh[0];
            3'b101:  w_bit = r_a_sh[0] | r_b_sh[0];
            3'b110:  w_bit = r_a_sh[0] ^ r_b_sh[0];
            default: w_bit = 1'b0;  // reserved encodings produce zero
        endcase
        w_result_next = {w_bit, r_result[WIDTH-1:1]};
    end

    // Next-state logic and handshake outputs
    always_comb begin
        w_state_next = r_state;
        o_ready      = (r_state != StRun);
        o_done       = (r_state == StDone);
        w_accept     = i_start & o_ready;
        w_last       = (r_state == StRun) && (r_cnt == LastIdx);
        case (r_state)
            StIdle:  if (i_start) w_state_next = StRun;
            StRun:   if (r_cnt == LastIdx) w_state_next = StDone;
            StDone:  w_state_next = i_start ? StRun : StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // State register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Operand shifters, carry flop, result shifter and flags
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_cnt       <= '0;
            r_a_sh      <= '0;
            r_b_sh      <= '0;
            r_op        <= 3'b000;
            r_carry     <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b1;
            r_negative  <= 1'b0;
            r_overflow  <= 1'b0;
            r_carry_out <= 1'b0;
        end else if (w_accept) begin
            r_a_sh  <= i_a;
            r_b_sh  <= i_b;
            r_op    <= i_cntrl;
            r_cnt   <= '0;
            // Subtract is A + ~B + 1: the +1 enters as the initial carry
            r_carry <= (i_cntrl == 3'b011);
        end else if (r_state == StRun) begin
            r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
            r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
            r_carry  <= w_cout;
            r_result <= w_result_next;
            r_cnt    <= r_cnt + CW'(1);
            if (w_last) begin
                // r_carry here is the carry into the MSB
                r_zero      <= (w_result_next == '0);
                r_negative  <= w_bit;
                r_overflow  <= w_arith & (r_carry ^ w_cout);
                r_carry_out <= w_arith & w_cout;
            end
        end
    end

    assign o_result    = r_result;
    assign o_zero      = r_zero;
    assign o_negative  = r_negative;
    assign o_overflow  = r_overflow;
    assign o_carry_out = r_carry_out;

endmodule

// File: tb/tb_alu_serial_seq.sv
// Self-checking bench for alu_serial_seq (WIDTH=8 main instance, WIDTH=64 aux).
module tb_alu_serial_seq;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         i_start;
    logic [7:0]   i_a;
    logic [7:0]   i_b;
    logic [2:0]   i_cntrl;
    logic         o_ready;
    logic         o_done;
    logic [7:0]   o_result;
    logic         o_zero;
    logic         o_negative;
    logic         o_overflow;
    logic         o_carry_out;

    logic         s64;
    logic [63:0]  a64;
    logic [63:0]  b64;
    logic [2:0]   c64;
    logic         ready64;
    logic         done64;
    logic [63:0]  res64;
    logic         zero64;
    logic         neg64;
    logic         ovf64;
    logic         cout64;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_serial_seq #(.WIDTH(W)) u_dut (
        .i_clk       (clk),
        .i_reset_n   (reset_n),
        .i_start     (i_start),
        .i_a         (i_a),
        .i_b         (i_b),
        .i_cntrl     (i_cntrl),
        .o_ready     (o_ready),
        .o_done      (o_done),
        .o_result    (o_result),
        .o_zero      (o_zero),
        .o_negative  (o_negative),
        .o_overflow  (o_overflow),
        .o_carry_out (o_carry_out)
    );

    alu_serial_seq #(.WIDTH(64)) u_dut64 (
        .i_clk       (clk),
        .i_reset_n   (reset_n),
        .i_start     (s64),
        .i_a         (a64),
        .i_b         (b64),
        .i_cntrl     (c64),
        .o_ready     (ready64),
        .o_done      (done64),
        .o_result    (res64),
        .o_zero      (zero64),
        .o_negative  (neg64),
        .o_overflow  (ovf64),
        .o_carry_out (cout64)
    );

    typedef struct packed {
        logic [7:0] res;
        logic       zero;
        logic       neg;
        logic       ovf;
        logic       cout;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        exp_t       e;
    } vec_t;

    task automatic chk_b(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_v(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model from integer arithmetic, not from a bit-serial slice
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        exp_t e;
        int   ua;
        int   ub;
        int   sa;
        int   sb;
        int   s;
        e  = '0;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        case (op)
            3'b000: e.res = b;
            3'b010: begin
                e.res  = 8'(ua + ub);
                e.cout = (ua + ub) > 255;
                s      = sa + sb;
                e.ovf  = (s > 127) || (s < -128);
            end
            3'b011: begin
                e.res  = 8'(ua - ub);
                e.cout = (ua >= ub);
                s      = sa - sb;
                e.ovf  = (s > 127) || (s < -128);
            end
            3'b100: e.res = a & b;
            3'b101: e.res = a | b;
            3'b110: e.res = a ^ b;
            default: e.res = 8'h00;
        endcase
        e.zero = (e.res == 8'h00);
        e.neg  = e.res[7];
        return e;
    endfunction

    task automatic cmp_out(input string tag, input exp_t e);
        chk_v({tag, ".result"}, 64'(o_result), 64'(e.res));
        chk_b({tag, ".zero"}, o_zero, e.zero);
        chk_b({tag, ".negative"}, o_negative, e.neg);
        chk_b({tag, ".overflow"}, o_overflow, e.ovf);
        chk_b({tag, ".carry_out"}, o_carry_out, e.cout);
    endtask

    // Runs one op; operands are scrambled after accept. poke>0 raises start
    // with garbage operands in the cycle after edge 'poke'.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                        input int poke, output int lat);
        int k;
        @(negedge clk);
        i_a     = a;
        i_b     = b;
        i_cntrl = op;
        i_start = 1'b1;
        k       = 0;
        lat     = -1;
        while (k < 200) begin
            @(posedge clk);
            #1;
            k++;
            if (k == 1) begin
                i_start = 1'b0;
                i_a     = 8'($urandom);
                i_b     = 8'($urandom);
                i_cntrl = 3'($urandom);
            end
            if (poke > 0 && k == poke) begin
                i_start = 1'b1;
                chk_b("ready_in_run", o_ready, 1'b0);
            end
            if (poke > 0 && k == poke + 1) i_start = 1'b0;
            if (o_done) begin
                lat = k;
                break;
            end
        end
        i_start = 1'b0;
        chk_v("latency", 64'(lat), 64'(W + 1));
    endtask

    vec_t vecs[11];

    initial begin
        int   lat;
        int   k;
        int   d1;
        int   d2;
        logic seen;
        exp_t e;
        logic [7:0] ra;
        logic [7:0] rb;
        logic [2:0] rop;

        vecs[0]  = '{8'h05, 8'h03, 3'b010, '{8'h08, 1'b0, 1'b0, 1'b0, 1'b0}};
        vecs[1]  = '{8'h7F, 8'h01, 3'b010, '{8'h80, 1'b0, 1'b1, 1'b1, 1'b0}};
        vecs[2]  = '{8'h03, 8'h03, 3'b011, '{8'h00, 1'b1, 1'b0, 1'b0, 1'b1}};
        vecs[3]  = '{8'hCA, 8'h5C, 3'b100, '{8'h48, 1'b0, 1'b0, 1'b0, 1'b0}};
        vecs[4]  = '{8'hCA, 8'h5C, 3'b101, '{8'hDE, 1'b0, 1'b1, 1'b0, 1'b0}};
        vecs[5]  = '{8'hCA, 8'h5C, 3'b110, '{8'h96, 1'b0, 1'b1, 1'b0, 1'b0}};
        vecs[6]  = '{8'hCA, 8'h5C, 3'b000, '{8'h5C, 1'b0, 1'b0, 1'b0, 1'b0}};
        vecs[7]  = '{8'hCA, 8'h5C, 3'b001, '{8'h00, 1'b1, 1'b0, 1'b0, 1'b0}};
        vecs[8]  = '{8'hCA, 8'h5C, 3'b111, '{8'h00, 1'b1, 1'b0, 1'b0, 1'b0}};
        vecs[9]  = '{8'hFF, 8'h01, 3'b010, '{8'h00, 1'b1, 1'b0, 1'b0, 1'b1}};
        vecs[10] = '{8'h80, 8'h01, 3'b011, '{8'h7F, 1'b0, 1'b0, 1'b1, 1'b1}};

        reset_n = 1'b1;
        i_start = 1'b0;
        i_a     = '0;
        i_b     = '0;
        i_cntrl = '0;
        s64     = 1'b0;
        a64     = '0;
        b64     = '0;
        c64     = '0;
        #2;
        reset_n = 1'b0;
        #1;
        cmp_out("reset", '{8'h00, 1'b1, 1'b0, 1'b0, 1'b0});
        chk_b("reset.ready", o_ready, 1'b1);
        chk_b("reset.done", o_done, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Directed table
        for (int i = 0; i < 11; i++) begin
            run8(vecs[i].a, vecs[i].b, vecs[i].op, 0, lat);
            cmp_out($sformatf("vec%0d", i), vecs[i].e);
        end

        // Randomized ops against the reference model, issued back to back
        for (int i = 0; i < 60; i++) begin
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rop = 3'($urandom_range(0, 7));
            e   = model(ra, rb, rop);
            run8(ra, rb, rop, 0, lat);
            cmp_out($sformatf("rnd%0d op%0d %0h,%0h", i, rop, ra, rb), e);
        end

        // Start during RUN cycle 3 is ignored
        run8(8'h05, 8'h03, 3'b010, 4, lat);
        cmp_out("ignore_start", '{8'h08, 1'b0, 1'b0, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        chk_b("ignore_start.no_extra_run", o_ready, 1'b1);
        chk_b("ignore_start.done_low", o_done, 1'b0);

        // Start held high through DONE: second op accepted in the DONE cycle
        @(negedge clk);
        i_a     = 8'h05;
        i_b     = 8'h03;
        i_cntrl = 3'b010;
        i_start = 1'b1;
        k       = 0;
        d1      = -1;
        d2      = -1;
        while (k < 100 && d2 < 0) begin
            @(posedge clk);
            #1;
            k++;
            if (o_done) begin
                if (d1 < 0) begin
                    d1 = k;
                    chk_v("b2b.res1", 64'(o_result), 64'h08);
                    chk_b("b2b.ready_in_done", o_ready, 1'b1);
                    i_a = 8'h7F;
                    i_b = 8'h01;
                end else begin
                    d2 = k;
                end
            end
        end
        i_start = 1'b0;
        chk_v("b2b.first_lat", 64'(d1), 64'd9);
        chk_v("b2b.spacing", 64'(d2 - d1), 64'd9);
        cmp_out("b2b.second", '{8'h80, 1'b0, 1'b1, 1'b1, 1'b0});
        @(posedge clk);
        #1;
        chk_b("b2b.done_pulse_1cyc", o_done, 1'b0);
        chk_b("b2b.idle_ready", o_ready, 1'b1);

        // Reset in RUN cycle 4 abandons the op
        @(negedge clk);
        i_a     = 8'h11;
        i_b     = 8'h22;
        i_cntrl = 3'b010;
        i_start = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        cmp_out("mid_reset", '{8'h00, 1'b1, 1'b0, 1'b0, 1'b0});
        chk_b("mid_reset.ready", o_ready, 1'b1);
        chk_b("mid_reset.done", o_done, 1'b0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (o_done) seen = 1'b1;
        end
        chk_b("mid_reset.no_done", seen, 1'b0);
        run8(8'hFF, 8'h01, 3'b010, 0, lat);
        cmp_out("after_reset", '{8'h00, 1'b1, 1'b0, 1'b0, 1'b1});

        // WIDTH=64 subtract
        @(negedge clk);
        a64 = 64'hFFFF_FFFF_FFFF_FFFF;
        b64 = 64'd1;
        c64 = 3'b011;
        s64 = 1'b1;
        k   = 0;
        lat = -1;
        while (k < 300) begin
            @(posedge clk);
            #1;
            k++;
            if (k == 1) begin
                s64 = 1'b0;
                a64 = '0;
                b64 = '0;
                c64 = 3'b000;
            end
            if (done64) begin
                lat = k;
                break;
            end
        end
        chk_v("w64.latency", 64'(lat), 64'd65);
        chk_v("w64.result", res64, 64'hFFFF_FFFF_FFFF_FFFE);
        chk_b("w64.negative", neg64, 1'b1);
        chk_b("w64.carry_out", cout64, 1'b1);
        chk_b("w64.overflow", ovf64, 1'b0);
        chk_b("w64.zero", zero64, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
